mr_data_return: RTL

MR_DATA_RETURN -- requirements
Module: mr_data_return

---
 rtl/mr_data_return.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mr_data_return.sv
// ---------------------------------------------------------------------------
// mr_data_return
//
// Memory-read data-return sequencer. On a request from the control unit it
// either performs one memory read (SRC[7]=1) and writes the returned word
// into the selected destination register, or completes immediately as a
// no-op (SRC[7]=0). A read that sees no MEM_ACK within TIMEOUT strobe cycles
// is aborted and reported with ERR alongside ACK. Every output is a flop.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   read request, sampled only while idle
//   src[15:0] in   control word: [7] memory enable, [1:0] destination
//                  (00 ACC, 01 IDX0, 10 IDX1, 11 PC)
//   addr[15:0]in   resolved read address
//   mem_addr  out  registered address to memory
//   mem_rd    out  read strobe, held until ack or timeout
//   mem_ack   in   one-cycle data-valid from memory
//   mem_data  in   read data, valid with mem_ack
//   wdata     out  write-back data to register file
//   wr_acc/wr_idx0/wr_idx1/wr_pc out  one-hot write enables
//   busy      out  high whenever not idle
//   ack       out  one-cycle completion pulse
//   err       out  one-cycle timeout flag, coincident with ack
// ---------------------------------------------------------------------------
module mr_data_return #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] src,
    input  logic [15:0] addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] wdata,
    output logic        wr_acc,
    output logic        wr_idx0,
    output logic        wr_idx1,
    output logic        wr_pc,
    output logic        busy,
    output logic        ack,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WB,
        S_NOP,
        S_TERR
    } state_t;

    // Counter value on the last strobe cycle; reaching it without an ack
    // means the strobe has already been high TIMEOUT cycles.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic [1:0]  dest;
    logic [1:0]  dest_next;
    logic [15:0] mem_addr_next;
    logic [15:0] wdata_next;

    // Only the enable bit and destination field of the control word matter.
    logic unused_src;
    assign unused_src = ^{src[15:8], src[6:2]};

    // State register plus registered outputs. Outputs are decoded from the
    // next state so they line up with the state they describe without any
    // combinational path to the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            dest     <= 2'd0;
            mem_addr <= 16'd0;
            wdata    <= 16'd0;
            mem_rd   <= 1'b0;
            wr_acc   <= 1'b0;
            wr_idx0  <= 1'b0;
            wr_idx1  <= 1'b0;
            wr_pc    <= 1'b0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_next;
            dest     <= dest_next;
            mem_addr <= mem_addr_next;
            wdata    <= wdata_next;
            mem_rd   <= (next_state == S_WAIT);
            busy     <= (next_state != S_IDLE);
            ack      <= (next_state == S_WB) || (next_state == S_NOP) ||
                        (next_state == S_TERR);
            err      <= (next_state == S_TERR);
            wr_acc   <= (next_state == S_WB) && (dest_next == 2'b00);
            wr_idx0  <= (next_state == S_WB) && (dest_next == 2'b01);
            wr_idx1  <= (next_state == S_WB) && (dest_next == 2'b10);
            wr_pc    <= (next_state == S_WB) && (dest_next == 2'b11);
        end
    end

    // Next-state logic. Request inputs are looked at only in idle, and
    // mem_ack only while waiting, so anything arriving elsewhere is dropped.
    // In the wait state an ack is tested before the timeout so that an ack
    // on the final strobe cycle still completes normally.
    always_comb begin
        next_state    = state;
        cnt_next      = cnt;
        dest_next     = dest;
        mem_addr_next = mem_addr;
        wdata_next    = wdata;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (src[7]) begin
                        mem_addr_next = addr;
                        dest_next     = src[1:0];
                        cnt_next      = 8'd0;
                        next_state    = S_WAIT;
                    end else begin
                        next_state = S_NOP;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    wdata_next = mem_data;
                    next_state = S_WB;
                end else if (cnt == LAST_CNT) begin
                    next_state = S_TERR;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            S_WB:    next_state = S_IDLE;
            S_NOP:   next_state = S_IDLE;
            S_TERR:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

endmodule
